// File: rtl/aes_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the AES encryption round controller.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARK   = 3'd1,
        SUB   = 3'd2,
        SHIFT = 3'd3,
        MIX   = 3'd4,
        FIN   = 3'd5
    } ctrl_state_e;

    localparam int NR_DEFAULT  = 14;
    localparam int TMO_DEFAULT = 16;

    // True for states that wait on a unit done pulse.
    function automatic logic is_step(input ctrl_state_e s);
        return (s == ARK) || (s == SUB) || (s == SHIFT) || (s == MIX);
    endfunction

endpackage

// File: rtl/mod_enc_step_timer.sv
// Per-step wait counter: holds at zero while cleared, counts cycles spent in a step,
// and flags the TMO-th cycle of waiting.
module mod_enc_step_timer
    import aes_ctrl_pkg::*;
#(
    parameter int TMO = TMO_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_count && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The entry cycle of a step reads zero, so the TMO-th waiting cycle reads TMO-1.
    assign o_expired = (r_cnt == CW'(TMO - 1));

endmodule

// File: rtl/mod_enc_round_ctrl.sv
// AES encryption round sequencer: pulses the addRoundKey/subBytes/shiftRows/mixColumns
// units in order, waits for each unit's done pulse, and times out stalled steps.
module mod_enc_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR  = NR_DEFAULT,
    parameter int TMO = TMO_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ready,
    output logic        en_ark,
    output logic        en_sub,
    output logic        en_shift,
    output logic        en_mix,
    input  logic        ark_done,
    input  logic        sub_done,
    input  logic        shift_done,
    input  logic        mix_done,
    output logic [3:0]  key_idx,
    output logic [3:0]  round,
    output logic        done,
    output logic        err,
    output ctrl_state_e state_dbg
);

    // Handshake: start is taken only on a cycle where ready=1 (IDLE); at any other time it
    // is ignored. Each unit sees a single-cycle enable and answers with a single-cycle done,
    // which may arrive in the enable cycle itself or any later cycle of the step.

    localparam logic [3:0] LAST = 4'(NR);

    ctrl_state_e r_state;
    ctrl_state_e w_next;
    logic        r_entry;
    logic [3:0]  r_round;
    logic [3:0]  r_key_idx;
    logic        r_err;
    logic        w_match;
    logic        w_more;
    logic        w_leave;
    logic        w_timeout;
    logic        w_expired;

    mod_enc_step_timer #(.TMO(TMO)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_leave || !is_step(r_state)),
        .i_count   (is_step(r_state)),
        .o_expired (w_expired)
    );

    always_comb begin
        w_match = 1'b0;
        w_next  = r_state;
        w_more  = (r_round < LAST);
        case (r_state)
            ARK:     w_match = ark_done;
            SUB:     w_match = sub_done;
            SHIFT:   w_match = shift_done;
            MIX:     w_match = mix_done;
            default: w_match = 1'b0;
        endcase
        w_timeout = is_step(r_state) && !w_match && w_expired;
        case (r_state)
            IDLE:    if (start)   w_next = ARK;
            ARK:     if (w_match) w_next = w_more ? SUB : FIN;
            SUB:     if (w_match) w_next = SHIFT;
            // The final round has no mixColumns step.
            SHIFT:   if (w_match) w_next = w_more ? MIX : ARK;
            MIX:     if (w_match) w_next = ARK;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_timeout) begin
            w_next = IDLE;
        end
        w_leave = (w_next != r_state);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_entry   <= 1'b0;
            r_round   <= 4'd0;
            r_key_idx <= 4'd0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_entry <= w_leave && is_step(w_next);
            if (r_state == IDLE && start) begin
                r_round   <= 4'd0;
                r_key_idx <= 4'd0;
                r_err     <= 1'b0;
            end
            if (r_state == ARK && w_match && w_more) begin
                r_round <= r_round + 4'd1;
            end
            // Round is unchanged on every transition into ARK, so the key tracks it there.
            if (w_leave && w_next == ARK && r_state != IDLE) begin
                r_key_idx <= r_round;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ready     = (r_state == IDLE);
    assign en_ark    = r_entry && (r_state == ARK);
    assign en_sub    = r_entry && (r_state == SUB);
    assign en_shift  = r_entry && (r_state == SHIFT);
    assign en_mix    = r_entry && (r_state == MIX);
    assign done      = (r_state == FIN);
    assign round     = r_round;
    assign key_idx   = r_key_idx;
    assign err       = r_err;
    assign state_dbg = r_state;

endmodule

// File: doc/mod_enc_round_ctrl.md
MOD_ENC_ROUND_CTRL -- requirements
Module: mod_enc_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 14, number of AES rounds (AES-256).
REQ-002 SHALL have parameter TMO, default 16, max cycles to wait for a unit done pulse.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begin encrypting one block; accepted only when ready=1.
REQ-006 SHALL have port ready, output, 1, high only in IDLE.
REQ-007 SHALL have ports en_ark, en_sub, en_shift, en_mix, output, 1 each, one-cycle enable pulses to the addRoundKey, subBytes, shiftRows and mixColumns units.
REQ-008 SHALL have ports ark_done, sub_done, shift_done, mix_done, input, 1 each, completion pulses from those units.
REQ-009 SHALL have port key_idx, output, 4, round-key index for addRoundKey, 0..NR.
REQ-010 SHALL have port round, output, 4, current round number, 0..NR.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when the block is complete.
REQ-012 SHALL have port err, output, 1, sticky timeout flag, cleared by accepted start or reset.

Function
REQ-013 SHALL use states IDLE, ARK, SUB, SHIFT, MIX, FIN.
REQ-014 SHALL, on start=1 in IDLE, set round=0 and key_idx=0, clear err, and enter ARK.
REQ-015 SHALL assert exactly one enable, for the entry cycle of ARK/SUB/SHIFT/MIX only, matching the state.
REQ-016 SHALL advance only on the done input matching the current state; the state changes at the edge that samples that done.
REQ-017 SHALL sequence ARK(done) -> round+1 then SUB if round<NR, else FIN.
REQ-018 SHALL sequence SUB -> SHIFT; SHIFT -> MIX if round<NR, SHIFT -> ARK if round==NR (final round skips mixColumns).
REQ-019 SHALL sequence MIX -> ARK; key_idx SHALL equal round throughout every ARK.
REQ-020 SHALL assert done for the single FIN cycle, then return to IDLE.
REQ-021 SHALL make each step take 2 cycles with a unit that responds one cycle after enable; with NR=14, 56 steps: en_ark in cycle 1 after the start edge, done in cycle 113.
REQ-022 SHALL ignore done pulses from non-current units, any done in IDLE/FIN, and start while ready=0.
REQ-023 SHALL count cycles spent waiting in a step; if TMO cycles elapse with no matching done, it SHALL set err and go to IDLE without asserting done.
REQ-024 SHALL treat a matching done in the enable cycle itself as valid (zero-wait unit).
REQ-025 SHALL keep round and key_idx stable in IDLE after completion (NR) or timeout (last value).

Reset
REQ-026 SHALL, on reset=1 at a clock edge, enter IDLE, zero round, key_idx, timer, err, done and all enables; reset wins over start and done at the same edge.
REQ-027 SHALL, on reset mid-block, abandon the block with no done pulse; outputs read 0 except ready=1 from the next cycle.

Structure
REQ-028 SHALL take the state enum, NR default, and TMO default from shared package aes_ctrl_pkg.
REQ-029 SHALL implement the wait counter as sub-module mod_enc_step_timer (clear, count, expired).
REQ-030 SHALL be controller-only, with no 128-bit datapath inside.

Verification
REQ-031 SHALL cover this scenario: start with all units done one cycle after enable -> en_ark at cycle 1, done at cycle 113, en_mix pulses exactly 13, key_idx sequence 0..14.
REQ-032 SHALL cover this scenario: unit delays done by 3 cycles -> each step lasts 4 cycles, no extra enables, done still single-cycle.
REQ-033 SHALL cover this scenario: mix_done never returns in round 5 -> err=1 after 16 cycles, ready=1, no done; next start clears err.
REQ-034 SHALL cover this scenario: spurious sub_done during ARK and start during round 3 -> ignored, sequence and latency unchanged.
REQ-035 SHALL cover this scenario: reset asserted in round 7 together with shift_done -> IDLE next cycle, round=0, no done.
REQ-036 SHALL cover this scenario: zero-wait units (done in the enable cycle) -> each step 1 cycle, done at cycle 57.
